// File: rtl/image_window_ctrl.sv
// image_window_ctrl: four-line rotating line buffer feeding a 3x3 Sobel stage.
// Pixels arrive in raster order; once three full lines are buffered, one packed
// 3x3 window is emitted per clock for every valid column, then the oldest line
// is released and o_intr asks the host for the next one.
module image_window_ctrl #(
  parameter int IMG_WIDTH = 512
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_pixel_data,
  input  logic        i_pixel_data_valid,
  output logic [71:0] o_pixel_data,
  output logic        o_pixel_data_valid,
  output logic        o_intr
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int TW = $clog2(4 * IMG_WIDTH + 1);

  typedef enum logic {
    IDLE,
    RD
  } state_t;

  state_t         state, state_nxt;
  logic [7:0]     lb [4][IMG_WIDTH];
  logic [CW-1:0]  wr_col;
  logic [1:0]     wr_buf;
  logic [CW-1:0]  rd_col;
  logic [1:0]     rd_buf;
  logic [TW-1:0]  total_pix;
  logic           line_done;
  logic [71:0]    win;

  // Line buffer storage: contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_pixel_data_valid && !i_rst) begin
      lb[wr_buf][wr_col] <= i_pixel_data;
    end
  end

  // Write pointer: column wraps at end of line and advances to the next buffer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_col <= '0;
      wr_buf <= '0;
    end else if (i_pixel_data_valid) begin
      if (wr_col == CW'(IMG_WIDTH - 1)) begin
        wr_col <= '0;
        wr_buf <= wr_buf + 2'd1;
      end else begin
        wr_col <= wr_col + CW'(1);
      end
    end
  end

  // Occupancy: a write and a line release in the same cycle both apply.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      total_pix <= '0;
    end else begin
      total_pix <= total_pix + TW'(i_pixel_data_valid)
                 - (line_done ? TW'(IMG_WIDTH) : TW'(0));
    end
  end

  // Read FSM state register and read pointers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      rd_col <= '0;
      rd_buf <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE || line_done) begin
        rd_col <= '0;
      end else begin
        rd_col <= rd_col + CW'(1);
      end
      if (line_done) begin
        rd_buf <= rd_buf + 2'd1;
      end
    end
  end

  // Read FSM next-state: start once three lines are held, stop at last column.
  always_comb begin
    state_nxt = state;
    line_done = 1'b0;
    case (state)
      IDLE: begin
        if (total_pix >= TW'(3 * IMG_WIDTH)) begin
          state_nxt = RD;
        end
      end
      RD: begin
        if (rd_col == CW'(IMG_WIDTH - 3)) begin
          line_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window assembly: row 0 is the oldest line, col 0 is the current read column.
  always_comb begin
    win = '0;
    for (int unsigned r = 0; r < 3; r++) begin
      for (int unsigned c = 0; c < 3; c++) begin
        win[(r * 3 + c) * 8 +: 8] = lb[rd_buf + 2'(r)][rd_col + CW'(c)];
      end
    end
  end

  // Registered outputs: data holds when no window is being read.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_pixel_data       <= '0;
      o_pixel_data_valid <= 1'b0;
      o_intr             <= 1'b0;
    end else begin
      o_pixel_data_valid <= (state == RD);
      o_intr             <= line_done;
      if (state == RD) begin
        o_pixel_data <= win;
      end
    end
  end

endmodule

// File: tb/tb_image_window_ctrl.sv
// Directed bench for image_window_ctrl with IMG_WIDTH=8.
module tb_image_window_ctrl;

  localparam int W = 8;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_pixel_data;
  logic        i_pixel_data_valid;
  logic [71:0] o_pixel_data;
  logic        o_pixel_data_valid;
  logic        o_intr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_count = 0;
  int last_wr_cyc = 0;

  logic [71:0] win_q[$];
  int          cyc_q[$];
  bit          intr_q[$];
  int          intr_cnt = 0;
  int          burst_cnt = 0;
  bit          prev_v = 1'b0;
  bit          s6_armed = 1'b0;
  int          s6_tp = -1;
  int          s6_wr = -1;
  bit          got;

  image_window_ctrl #(.IMG_WIDTH(W)) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_pixel_data       (i_pixel_data),
    .i_pixel_data_valid (i_pixel_data_valid),
    .o_pixel_data       (o_pixel_data),
    .o_pixel_data_valid (o_pixel_data_valid),
    .o_intr             (o_intr)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  always @(negedge i_clk) begin
    if (o_pixel_data_valid) begin
      win_q.push_back(o_pixel_data);
      cyc_q.push_back(cyc);
      intr_q.push_back(o_intr);
    end
    if (o_intr) intr_cnt++;
    if (o_pixel_data_valid && !prev_v) burst_cnt++;
    prev_v = o_pixel_data_valid;
    if (o_intr && s6_armed) begin
      s6_tp = int'(dut.total_pix);
      s6_wr = wr_count;
      s6_armed = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] exp_win(input int line, input int col, input int off);
    logic [71:0] v;
    v = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        v[(r * 3 + c) * 8 +: 8] = 8'((line + r) * W + col + c + off);
    return v;
  endfunction

  task automatic put(input int val);
    i_pixel_data = 8'(val);
    i_pixel_data_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_pixel_data_valid = 1'b0;
    wr_count++;
    last_wr_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic clear_mon();
    win_q.delete();
    cyc_q.delete();
    intr_q.delete();
    intr_cnt = 0;
    burst_cnt = 0;
  endtask

  task automatic do_reset();
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    i_pixel_data_valid = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    wr_count = 0;
    clear_mon();
  endtask

  initial begin
    i_rst = 1'b1;
    i_pixel_data = '0;
    i_pixel_data_valid = 1'b0;
    #3;
    chk("reset_data", o_pixel_data, 72'h0);
    chk("reset_valid", 72'(o_pixel_data_valid), 72'h0);
    chk("reset_intr", 72'(o_intr), 72'h0);
    idle(2);
    i_rst = 1'b0;
    clear_mon();

    // Scenario 1: one burst from 24 back-to-back pixels.
    for (int i = 0; i < 24; i++) put(i);
    idle(14);
    chk("s1_count", 72'(win_q.size()), 72'd6);
    if (win_q.size() == 6) begin
      chk("s1_start", 72'(cyc_q[0]), 72'(last_wr_cyc + 2));
      chk("s1_w0", win_q[0], 72'h12_11_10_0A_09_08_02_01_00);
      chk("s1_w5", win_q[5], 72'h17_16_15_0F_0E_0D_07_06_05);
      chk("s1_intr_last", 72'(intr_q[5]), 72'h1);
    end
    chk("s1_intr_cnt", 72'(intr_cnt), 72'd1);
    chk("s1_bursts", 72'(burst_cnt), 72'd1);
    clear_mon();

    // Scenario 2: one more line gives a second burst.
    for (int i = 24; i < 32; i++) put(i);
    idle(14);
    chk("s2_count", 72'(win_q.size()), 72'd6);
    if (win_q.size() == 6) begin
      chk("s2_start", 72'(cyc_q[0]), 72'(last_wr_cyc + 2));
      chk("s2_w0", win_q[0], 72'h1A_19_18_12_11_10_0A_09_08);
    end
    chk("s2_intr_cnt", 72'(intr_cnt), 72'd1);

    // Scenarios 3 and 6: 48 pixels from reset, buffer wrap and occupancy.
    do_reset();
    s6_armed = 1'b1;
    for (int i = 0; i < 48; i++) put(i);
    idle(40);
    chk("s3_count", 72'(win_q.size()), 72'd24);
    chk("s3_bursts", 72'(burst_cnt), 72'd4);
    chk("s3_intr_cnt", 72'(intr_cnt), 72'd4);
    if (win_q.size() == 24) begin
      for (int i = 0; i < 24; i++) begin
        chk($sformatf("s3_win%0d", i), win_q[i], exp_win(i / 6, i % 6, 0));
        chk($sformatf("s3_intr%0d", i), 72'(intr_q[i]), 72'((i % 6) == 5));
      end
      chk("s3_b4_w0", win_q[18], 72'h2A_29_28_22_21_20_1A_19_18);
    end
    chk("s3_total_end", 72'(dut.total_pix), 72'd16);
    chk("s6_captured", 72'(s6_armed), 72'h0);
    chk("s6_total", 72'(s6_tp), 72'(s6_wr - 8));

    // Scenario 4: every-other-cycle writes.
    do_reset();
    for (int i = 0; i < 24; i++) begin
      put(i);
      if (i != 23) idle(1);
    end
    idle(14);
    chk("s4_count", 72'(win_q.size()), 72'd6);
    if (win_q.size() == 6) begin
      chk("s4_start", 72'(cyc_q[0]), 72'(last_wr_cyc + 2));
      chk("s4_w0", win_q[0], 72'h12_11_10_0A_09_08_02_01_00);
      chk("s4_w5", win_q[5], 72'h17_16_15_0F_0E_0D_07_06_05);
    end
    chk("s4_intr_cnt", 72'(intr_cnt), 72'd1);

    // Scenario 5: asynchronous reset during the third window.
    do_reset();
    for (int i = 0; i < 24; i++) put(i);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge i_clk);
      #1;
      if (win_q.size() >= 3) got = 1'b1;
    end
    chk("s5_reached_w3", 72'(got), 72'h1);
    #1;
    i_rst = 1'b1;
    #1;
    chk("s5_rst_valid", 72'(o_pixel_data_valid), 72'h0);
    chk("s5_rst_intr", 72'(o_intr), 72'h0);
    chk("s5_rst_data", o_pixel_data, 72'h0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    wr_count = 0;
    clear_mon();
    for (int i = 0; i < 23; i++) put(i + 100);
    idle(12);
    chk("s5_no_output", 72'(win_q.size()), 72'd0);
    put(123);
    idle(14);
    chk("s5_count", 72'(win_q.size()), 72'd6);
    if (win_q.size() == 6) begin
      chk("s5_start", 72'(cyc_q[0]), 72'(last_wr_cyc + 2));
      chk("s5_w0", win_q[0], 72'h76_75_74_6E_6D_6C_66_65_64);
    end
    chk("s5_intr_cnt", 72'(intr_cnt), 72'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_window_ctrl.md
Name: image_window_ctrl

Overview:
- Line-buffer / window generator directly upstream of the 3x3 Sobel convolution stage.
- Accepts a raster stream of 8-bit grayscale pixels, one per valid cycle, and stores them in four rotating line buffers.
- Once three full lines are stored, emits one packed 3x3 window (72 bits) per clock for every valid column of the line.
- Pulses an interrupt each time a line is consumed, so the DMA/host sends the next line.

Parameters:
- IMG_WIDTH, 512, pixels per image line. Legal range is 4 or more; the bench uses 8.

Ports:
- i_clk  input  1  clock, all logic on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_pixel_data  input  8  incoming pixel, unsigned.
- i_pixel_data_valid  input  1  pixel qualifier.
- o_pixel_data  output  72  3x3 window to the convolution stage.
- o_pixel_data_valid  output  1  window qualifier.
- o_intr  output  1  one-cycle pulse when a line is released.

Behaviour:
- Storage:
  - Four line buffers lb0..lb3, each IMG_WIDTH x 8.
  - Buffer contents are not reset.
- Write side:
  - Each cycle with i_pixel_data_valid=1 writes lb[wrBuf][wrCol].
  - wrCol wraps from IMG_WIDTH-1 to 0. At that wrap, wrBuf increments mod 4 (3 wraps to 0).
  - Invalid cycles write nothing. There is no backpressure: the read rate exceeds the maximum write rate.
- Occupancy counter totalPix:
  - Width clog2(4*IMG_WIDTH+1).
  - Next value = totalPix + (write ? 1 : 0) - (lineDone ? IMG_WIDTH : 0).
  - A write and a lineDone in the same cycle are both applied.
- Read FSM, state IDLE:
  - If totalPix >= 3*IMG_WIDTH, go to RD on the next edge and set rdCol=0.
  - Otherwise stay in IDLE.
- Read FSM, state RD:
  - Each cycle reads columns rdCol, rdCol+1, rdCol+2 from buffers rdBuf, rdBuf+1, rdBuf+2 (mod 4).
  - rdCol increments each cycle.
  - When rdCol == IMG_WIDTH-3, assert lineDone. On that edge: go to IDLE, rdBuf increments mod 4, totalPix drops by IMG_WIDTH.
- Window packing:
  - Byte k = row*3+col sits at o_pixel_data[k*8 +: 8].
  - row 0 = oldest line (rdBuf); col 0 = column rdCol.
- Output timing (registered outputs):
  - o_pixel_data and o_pixel_data_valid update one edge after the RD cycle that addressed them.
  - The first valid window appears 2 edges after the edge on which totalPix reaches 3*IMG_WIDTH.
  - IMG_WIDTH-2 consecutive valid windows are produced per line.
  - o_pixel_data_valid is low for at least 1 cycle between bursts.
  - o_pixel_data holds its last value when not valid.
- o_intr:
  - Registered; high for exactly the cycle carrying the last window of a burst.
- Reset (i_rst=1, at any time including mid-burst):
  - Immediately: o_pixel_data=0, o_pixel_data_valid=0, o_intr=0.
  - wrCol, wrBuf, rdCol, rdBuf and totalPix clear to 0; FSM returns to IDLE.
  - Previously written pixels are considered lost.

Test Plan (IMG_WIDTH=8, pixel value = stream index mod 256):
1. Write 24 pixels back-to-back (values 0..23):
   - 6 valid windows, starting 2 edges after the 24th write.
   - Window0 bytes k0..k8 = 0,1,2,8,9,10,16,17,18.
   - Window5 = 5,6,7,13,14,15,21,22,23.
   - o_intr high with window5; no further output.
2. Continue with 8 more pixels (24..31):
   - Second burst of 6 windows.
   - Window0 = 8,9,10,16,17,18,24,25,26; one o_intr.
3. From reset, write 48 pixels back-to-back:
   - Exactly 4 bursts and 4 o_intr pulses.
   - Burst 4 exercises buffer wrap (rows lb3, lb0, lb1); its window0 = 24,25,26,32,33,34,40,41,42.
   - No 5th burst (totalPix=16).
4. Repeat scenario 1 with i_pixel_data_valid high every other cycle:
   - Identical window contents and count.
   - Burst starts 2 edges after the 24th valid write.
5. Assert i_rst during the 3rd window of scenario 1:
   - o_pixel_data_valid, o_intr and o_pixel_data go to 0 without waiting for a clock edge.
   - After release, 23 writes produce no output; the 24th triggers a burst whose window0 is built from the new data.
6. Write into lb3 while burst 1 reads lb0..lb2 (scenario 3 timing):
   - Burst 1 windows are unaffected.
   - totalPix after burst 1's lineDone edge = pixels written − 8.
